// File: rtl/turbo_pkg.sv
// rtl/turbo_pkg.sv - shared types and constants for the turbo tail sequencer
package turbo_pkg;

   localparam int K_MIN      = 40;
   localparam int K_MAX      = 6144;
   localparam int TAIL_LEN   = 3;
   localparam int TAIL_BEATS = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_TAIL1,
      ST_TAIL2,
      ST_EMIT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/turbo_tail_sequencer_tail_reorder_buf.sv
// rtl/turbo_tail_sequencer_tail_reorder_buf.sv - termination bit capture and triplet reorder
// Encoder 1 tail fills slots 0..5 as x,z pairs, encoder 2 fills 6..11; beat b reads slots 3b..3b+2.
module tail_reorder_buf
   import turbo_pkg::*;
(
   input  logic       clock,
   input  logic       aclr,
   input  logic       i_cap1,
   input  logic       i_cap2,
   input  logic [1:0] i_idx,
   input  logic       i_x1,
   input  logic       i_z1,
   input  logic       i_x2,
   input  logic       i_z2,
   input  logic [1:0] i_beat,
   output logic       o_d0,
   output logic       o_d1,
   output logic       o_d2
);

   localparam int ENC_BITS = 2 * TAIL_LEN;

   logic [2*ENC_BITS-1:0] r_buf;
   logic [3:0]            w_slot1;
   logic [3:0]            w_slot2;
   logic [3:0]            w_base;

   assign w_slot1 = {1'b0, i_idx, 1'b0};
   assign w_slot2 = w_slot1 + 4'(ENC_BITS);
   assign w_base  = {1'b0, i_beat, 1'b0} + {2'b00, i_beat};

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         r_buf <= '0;
      end else begin
         if (i_cap1) begin
            r_buf[w_slot1]        <= i_x1;
            r_buf[w_slot1 + 4'd1] <= i_z1;
         end
         if (i_cap2) begin
            r_buf[w_slot2]        <= i_x2;
            r_buf[w_slot2 + 4'd1] <= i_z2;
         end
      end
   end

   assign o_d0 = r_buf[w_base];
   assign o_d1 = r_buf[w_base + 4'd1];
   assign o_d2 = r_buf[w_base + 4'd2];

endmodule

// File: rtl/turbo_tail_sequencer.sv
// rtl/turbo_tail_sequencer.sv - LTE turbo encoder termination sequencer and triplet formatter
// PARALLEL_TAIL_EN: terminate both constituent encoders together in one 3-cycle tail phase.
module turbo_tail_sequencer
   import turbo_pkg::*;
#(
   parameter int KW    = 13,
   parameter int K_MIN = turbo_pkg::K_MIN,
   parameter int K_MAX = turbo_pkg::K_MAX
)(
   input  logic          clock,
   input  logic          aclr,
   input  logic          start,
   input  logic [KW-1:0] blk_len,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          x1,
   input  logic          z1,
   input  logic          x2,
   input  logic          z2,
   output logic          enc1_en,
   output logic          enc2_en,
   output logic          tail1,
   output logic          tail2,
   output logic          d0,
   output logic          d1,
   output logic          d2,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic          done,
   output logic          len_err
);

   localparam logic [KW-1:0] LP_K_MIN     = KW'(K_MIN);
   localparam logic [KW-1:0] LP_K_MAX     = KW'(K_MAX);
   localparam logic [1:0]    LP_LAST_TAIL = 2'(TAIL_LEN - 1);
   localparam logic [1:0]    LP_LAST_BEAT = 2'(TAIL_BEATS - 1);

   state_t        r_state;
   state_t        w_next;
   logic [KW-1:0] r_k;
   logic [KW-1:0] r_bit_cnt;
   logic [1:0]    r_idx;
   logic          r_len_err;

   logic          w_len_ok;
   logic          w_last_bit;
   logic          w_xfer;
   logic          w_cap1;
   logic          w_cap2;
   logic          w_buf_d0;
   logic          w_buf_d1;
   logic          w_buf_d2;

   assign w_len_ok   = (blk_len >= LP_K_MIN) && (blk_len <= LP_K_MAX);
   assign w_last_bit = (r_bit_cnt == r_k - 1'b1);
   assign len_err    = r_len_err;

   always_comb begin
      w_next    = r_state;
      w_xfer    = 1'b0;
      w_cap1    = 1'b0;
      w_cap2    = 1'b0;
      in_ready  = 1'b0;
      enc1_en   = 1'b0;
      enc2_en   = 1'b0;
      tail1     = 1'b0;
      tail2     = 1'b0;
      out_valid = 1'b0;
      d0        = 1'b0;
      d1        = 1'b0;
      d2        = 1'b0;
      busy      = (r_state != ST_IDLE);
      done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && w_len_ok)
               w_next = ST_DATA;
         end
         ST_DATA: begin
            // Encoders only advance when a triplet can leave in the same cycle.
            w_xfer = in_valid && out_ready;
            if (w_xfer) begin
               in_ready  = 1'b1;
               enc1_en   = 1'b1;
               enc2_en   = 1'b1;
               out_valid = 1'b1;
               d0        = x1;
               d1        = z1;
               d2        = z2;
               if (w_last_bit)
                  w_next = ST_TAIL1;
            end
         end
         ST_TAIL1: begin
            tail1   = 1'b1;
            enc1_en = 1'b1;
            w_cap1  = 1'b1;
`ifdef PARALLEL_TAIL_EN
            tail2   = 1'b1;
            enc2_en = 1'b1;
            w_cap2  = 1'b1;
            if (r_idx == LP_LAST_TAIL)
               w_next = ST_EMIT;
`else
            if (r_idx == LP_LAST_TAIL)
               w_next = ST_TAIL2;
`endif
         end
         ST_TAIL2: begin
            tail2   = 1'b1;
            enc2_en = 1'b1;
            w_cap2  = 1'b1;
            if (r_idx == LP_LAST_TAIL)
               w_next = ST_EMIT;
         end
         ST_EMIT: begin
            out_valid = 1'b1;
            d0        = w_buf_d0;
            d1        = w_buf_d1;
            d2        = w_buf_d2;
            if (out_ready && (r_idx == LP_LAST_BEAT))
               w_next = ST_DONE;
         end
         ST_DONE: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         r_state   <= ST_IDLE;
         r_k       <= '0;
         r_bit_cnt <= '0;
         r_idx     <= '0;
         r_len_err <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_len_err <= (r_state == ST_IDLE) && start && !w_len_ok;
         if ((r_state == ST_IDLE) && start && w_len_ok) begin
            r_k       <= blk_len;
            r_bit_cnt <= '0;
         end else if (w_xfer && !w_last_bit) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         // r_idx doubles as tail cycle index and emit beat index.
         if (w_next != r_state)
            r_idx <= '0;
         else if ((r_state == ST_TAIL1) || (r_state == ST_TAIL2) ||
                  ((r_state == ST_EMIT) && out_ready))
            r_idx <= r_idx + 2'd1;
      end
   end

   tail_reorder_buf u_tail_buf (
      .clock  (clock),
      .aclr   (aclr),
      .i_cap1 (w_cap1),
      .i_cap2 (w_cap2),
      .i_idx  (r_idx),
      .i_x1   (x1),
      .i_z1   (z1),
      .i_x2   (x2),
      .i_z2   (z2),
      .i_beat (r_idx),
      .o_d0   (w_buf_d0),
      .o_d1   (w_buf_d1),
      .o_d2   (w_buf_d2)
   );

endmodule

// File: tb/tb_turbo_tail_sequencer.sv
// tb/tb_turbo_tail_sequencer.sv - directed bench with RSC encoder models for turbo_tail_sequencer
module tb_turbo_tail_sequencer;

   localparam int KW = 13;
`ifdef PARALLEL_TAIL_EN
   localparam int EXP_GAP = 3;
`else
   localparam int EXP_GAP = 6;
`endif

   logic          clock = 1'b0;
   logic          aclr = 1'b1;
   logic          start = 1'b0;
   logic [KW-1:0] blk_len = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          x1, z1, x2, z2;
   logic          enc1_en, enc2_en, tail1, tail2;
   logic          d0, d1, d2;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          busy, done, len_err;

   // upstream constituent encoders (g0=13 feedback, g1=15 parity)
   logic          c1 = 1'b0, c2 = 1'b0, enc_rst = 1'b0;
   logic [2:0]    e1_s = '0, e2_s = '0;
   logic          a1, a2;

   assign a1 = tail1 ? 1'b0 : (c1 ^ e1_s[1] ^ e1_s[2]);
   assign a2 = tail2 ? 1'b0 : (c2 ^ e2_s[1] ^ e2_s[2]);
   assign x1 = tail1 ? (e1_s[1] ^ e1_s[2]) : c1;
   assign x2 = tail2 ? (e2_s[1] ^ e2_s[2]) : c2;
   assign z1 = a1 ^ e1_s[0] ^ e1_s[2];
   assign z2 = a2 ^ e2_s[0] ^ e2_s[2];

   always @(posedge clock) begin
      if (enc_rst) begin
         e1_s <= '0;
         e2_s <= '0;
      end else begin
         if (enc1_en) e1_s <= {e1_s[1:0], a1};
         if (enc2_en) e2_s <= {e2_s[1:0], a2};
      end
   end

   always #5 clock = ~clock;

   turbo_tail_sequencer #(.KW(KW)) dut (
      .clock(clock), .aclr(aclr), .start(start), .blk_len(blk_len),
      .in_valid(in_valid), .in_ready(in_ready),
      .x1(x1), .z1(z1), .x2(x2), .z2(z2),
      .enc1_en(enc1_en), .enc2_en(enc2_en), .tail1(tail1), .tail2(tail2),
      .d0(d0), .d1(d1), .d2(d2), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .len_err(len_err)
   );

   int checks = 0;
   int failures = 0;

   logic [2:0] got[$];
   logic [2:0] exp_q[$];
   int n_in, n_done, busy_bad, en_bad, tail_bad, hold_bad, t1_cnt, t2_cnt;
   int last_cyc, emit_cyc, stall_cyc, first_bad;
   bit aborted, post_busy, post_done;
   logic [11:0] abort_out;

   function automatic logic patbit(input int sel, input int enc, input int i);
      case (sel)
         0:       return 1'b0;
         1:       return 1'b1;
         default: return (enc == 1) ? (((i * 7 + 3) % 5) < 2) : ((i % 3) == 1);
      endcase
   endfunction

   task automatic build_exp(input int k, input int sel);
      logic [2:0] s1, s2;
      logic       c, a, za, zb;
      logic [2:0] tx1, tz1, tx2, tz2;
      exp_q.delete();
      s1 = '0;
      s2 = '0;
      for (int i = 0; i < k; i++) begin
         c  = patbit(sel, 1, i);
         a  = c ^ s1[1] ^ s1[2];
         za = a ^ s1[0] ^ s1[2];
         s1 = {s1[1:0], a};
         exp_q.push_back({c, za, 1'b0});
         c  = patbit(sel, 2, i);
         a  = c ^ s2[1] ^ s2[2];
         zb = a ^ s2[0] ^ s2[2];
         s2 = {s2[1:0], a};
         exp_q[i][0] = zb;
      end
      for (int j = 0; j < 3; j++) begin
         tx1[j] = s1[1] ^ s1[2];
         tz1[j] = s1[0] ^ s1[2];
         s1 = {s1[1:0], 1'b0};
         tx2[j] = s2[1] ^ s2[2];
         tz2[j] = s2[0] ^ s2[2];
         s2 = {s2[1:0], 1'b0};
      end
      exp_q.push_back({tx1[0], tz1[0], tx1[1]});
      exp_q.push_back({tz1[1], tx1[2], tz1[2]});
      exp_q.push_back({tx2[0], tz2[0], tx2[1]});
      exp_q.push_back({tz2[1], tx2[2], tz2[2]});
   endtask

   function automatic int count_mism();
      int bad = 0;
      first_bad = -1;
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         if (got[i] !== exp_q[i]) begin
            if (bad == 0) first_bad = i;
            bad++;
         end
      return bad;
   endfunction

   task automatic run_block(input int k, input int sel, input int stall_bit,
                            input bit stall_emit, input int abort_bit,
                            input bit iv_gaps, input int budget);
      int  cyc = 0, stall_left = 0;
      bit  s1 = 0, s2 = 0, fin = 0, hold_valid = 0;
      logic [2:0] hold_trip = '0;
      got.delete();
      n_in = 0; n_done = 0; busy_bad = 0; en_bad = 0; tail_bad = 0; hold_bad = 0;
      t1_cnt = 0; t2_cnt = 0; last_cyc = -1; emit_cyc = -1; stall_cyc = 0;
      aborted = 0; post_busy = 0; post_done = 0; abort_out = '0;
      @(negedge clock);
      start = 1'b1; blk_len = KW'(k); enc_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clock);
      start = 1'b0; enc_rst = 1'b0;
      while (!fin && cyc < budget) begin
         if (abort_bit >= 0 && n_in == abort_bit) begin
            aclr = 1'b1;
            #1;
            abort_out = {in_ready, enc1_en, enc2_en, tail1, tail2, d0, d1, d2,
                         out_valid, busy, done, len_err};
            aborted = 1;
            fin = 1;
            @(negedge clock);
            aclr = 1'b0;
         end else begin
            if (stall_left > 0) begin
               stall_left--; out_ready = 1'b0;
            end else if (!s1 && stall_bit >= 0 && n_in == stall_bit) begin
               s1 = 1; stall_left = 4; out_ready = 1'b0;
            end else if (!s2 && stall_emit && got.size() == k + 2 && out_valid) begin
               s2 = 1; stall_left = 4; out_ready = 1'b0;
            end else begin
               out_ready = 1'b1;
            end
            if (!out_ready) stall_cyc++;
            in_valid = !(iv_gaps && (cyc % 4 == 3));
            c1 = (n_in < k) ? patbit(sel, 1, n_in) : 1'b0;
            c2 = (n_in < k) ? patbit(sel, 2, n_in) : 1'b0;
            #1;
            if (!busy) busy_bad++;
            if (tail1 || tail2) begin
               if (in_ready || out_valid || tail1 !== enc1_en || tail2 !== enc2_en) tail_bad++;
               if (tail1) t1_cnt++;
               if (tail2) t2_cnt++;
            end else if (n_in < k) begin
               if (in_ready !== (in_valid && out_ready)) en_bad++;
               if (enc1_en !== in_ready || enc2_en !== in_ready || out_valid !== in_ready) en_bad++;
            end
            if (out_valid && !out_ready) begin
               if (hold_valid && {d0, d1, d2} !== hold_trip) hold_bad++;
               hold_valid = 1;
               hold_trip = {d0, d1, d2};
            end else begin
               hold_valid = 0;
            end
            if (out_valid && out_ready) begin
               if (got.size() == k - 1) last_cyc = cyc;
               if (got.size() == k) emit_cyc = cyc;
               got.push_back({d0, d1, d2});
            end
            if (in_ready) n_in++;
            if (done) begin
               n_done++;
               fin = 1;
            end
            cyc++;
            if (!fin) @(negedge clock);
         end
      end
      if (fin && !aborted) begin
         @(negedge clock);
         in_valid = 1'b0;
         #1;
         post_busy = busy;
         post_done = done;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      #1;
      checks++;
      if ({in_ready, enc1_en, enc2_en, tail1, tail2, d0, d1, d2, out_valid, busy, done, len_err} !== 12'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0", {in_ready, enc1_en, enc2_en, tail1, tail2,
                  d0, d1, d2, out_valid, busy, done, len_err});
      end
      @(negedge clock);
      aclr = 1'b0;
   endtask

   task automatic test_zero_block();
      int bad;
      run_block(40, 0, -1, 0, -1, 0, 300);
      build_exp(40, 0);
      bad = count_mism();
      checks++; if (got.size() != 44) begin failures++; $display("FAIL zero_beats got=%0d exp=44", got.size()); end
      checks++; if (bad != 0) begin failures++; $display("FAIL zero_triplets bad=%0d first=%0d exp=0", bad, first_bad); end
      checks++; if (n_done != 1) begin failures++; $display("FAIL zero_done_or_timeout got=%0d exp=1", n_done); end
      checks++; if (busy_bad != 0) begin failures++; $display("FAIL zero_busy_low got=%0d exp=0", busy_bad); end
      checks++; if (post_busy !== 1'b0 || post_done !== 1'b0) begin failures++; $display("FAIL zero_after_done busy=%b done=%b exp=0,0", post_busy, post_done); end
      checks++; if (t1_cnt != 3 || t2_cnt != 3) begin failures++; $display("FAIL zero_tail_cycles t1=%0d t2=%0d exp=3,3", t1_cnt, t2_cnt); end
      checks++; if (tail_bad != 0 || en_bad != 0) begin failures++; $display("FAIL zero_enables tail_bad=%0d en_bad=%0d exp=0", tail_bad, en_bad); end
      checks++; if (emit_cyc - last_cyc - 1 != EXP_GAP) begin failures++; $display("FAIL zero_gap got=%0d exp=%0d", emit_cyc - last_cyc - 1, EXP_GAP); end
   endtask

   task automatic test_ones_model();
      int bad;
      run_block(40, 1, -1, 0, -1, 0, 300);
      build_exp(40, 1);
      bad = count_mism();
      checks++; if (got.size() != 44) begin failures++; $display("FAIL ones_beats got=%0d exp=44", got.size()); end
      checks++; if (bad != 0) begin failures++; $display("FAIL ones_triplets bad=%0d first=%0d got=%b exp=%b", bad, first_bad, got[first_bad], exp_q[first_bad]); end
      checks++; if (n_done != 1) begin failures++; $display("FAIL ones_done_or_timeout got=%0d exp=1", n_done); end
      checks++; if (emit_cyc - last_cyc - 1 != EXP_GAP) begin failures++; $display("FAIL ones_gap got=%0d exp=%0d", emit_cyc - last_cyc - 1, EXP_GAP); end
   endtask

   task automatic test_backpressure();
      int bad;
      run_block(40, 1, 10, 1, -1, 0, 300);
      build_exp(40, 1);
      bad = count_mism();
      checks++; if (stall_cyc != 10) begin failures++; $display("FAIL bp_stall_cycles got=%0d exp=10", stall_cyc); end
      checks++; if (en_bad != 0) begin failures++; $display("FAIL bp_enables got=%0d exp=0", en_bad); end
      checks++; if (hold_bad != 0) begin failures++; $display("FAIL bp_hold got=%0d exp=0", hold_bad); end
      checks++; if (got.size() != 44) begin failures++; $display("FAIL bp_beats got=%0d exp=44", got.size()); end
      checks++; if (bad != 0) begin failures++; $display("FAIL bp_triplets bad=%0d first=%0d exp=0", bad, first_bad); end
      checks++; if (n_done != 1) begin failures++; $display("FAIL bp_done_or_timeout got=%0d exp=1", n_done); end
   endtask

   task automatic test_mixed_gaps();
      int bad;
      run_block(40, 2, -1, 0, -1, 1, 300);
      build_exp(40, 2);
      bad = count_mism();
      checks++; if (bad != 0 || got.size() != 44) begin failures++; $display("FAIL mixed_triplets bad=%0d beats=%0d exp=0,44", bad, got.size()); end
      checks++; if (en_bad != 0 || tail_bad != 0) begin failures++; $display("FAIL mixed_enables en_bad=%0d tail_bad=%0d exp=0", en_bad, tail_bad); end
      checks++; if (n_done != 1) begin failures++; $display("FAIL mixed_done_or_timeout got=%0d exp=1", n_done); end
   endtask

   task automatic test_len_err();
      int lens[2] = '{39, 6145};
      int bad;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         start = 1'b1; blk_len = KW'(lens[i]);
         @(negedge clock);
         start = 1'b0;
         #1;
         checks++; if (len_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL len_err_pulse k=%0d len_err=%b busy=%b exp=1,0", lens[i], len_err, busy); end
         @(negedge clock);
         #1;
         checks++; if (len_err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL len_err_clear k=%0d len_err=%b busy=%b exp=0,0", lens[i], len_err, busy); end
      end
      run_block(6144, 0, -1, 0, -1, 0, 6400);
      build_exp(6144, 0);
      bad = count_mism();
      checks++; if (got.size() != 6148) begin failures++; $display("FAIL kmax_beats got=%0d exp=6148", got.size()); end
      checks++; if (bad != 0 || n_done != 1) begin failures++; $display("FAIL kmax_block bad=%0d done=%0d exp=0,1", bad, n_done); end
   endtask

   task automatic test_abort();
      int bad;
      int late_done = 0;
      run_block(64, 2, -1, 0, 20, 0, 300);
      checks++; if (!aborted || abort_out !== 12'b0) begin failures++; $display("FAIL abort_outputs aborted=%0d got=%b exp=0", aborted, abort_out); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         #1;
         if (done || busy) late_done++;
      end
      checks++; if (n_done != 0 || late_done != 0) begin failures++; $display("FAIL abort_no_done done=%0d late=%0d exp=0,0", n_done, late_done); end
      run_block(40, 2, -1, 0, -1, 0, 300);
      build_exp(40, 2);
      bad = count_mism();
      checks++; if (bad != 0 || got.size() != 44 || n_done != 1) begin failures++; $display("FAIL abort_next_block bad=%0d beats=%0d done=%0d exp=0,44,1", bad, got.size(), n_done); end
   endtask

   initial begin
      test_reset();
      test_zero_block();
      test_ones_model();
      test_backpressure();
      test_mixed_gaps();
      test_len_err();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
